// File: rtl/mem_responder.sv
// Word-addressed data memory target with programmable wait states and error responses.
// Optional MEM_RESPONDER_ALIGN_CHECK_EN: misaligned byte addresses also raise rsp_err.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // once rsp_valid rises, rsp_rdata/rsp_err stay stable until rsp_ready is seen.
  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          lat_write;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          c_write;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic          c_err;
  logic          commit;
  logic [AW-1:0] c_idx;

  // With zero wait states the commit happens on the acceptance edge, so the live
  // request fields are used instead of the (not yet loaded) latched copy.
  always_comb begin
    c_write = lat_write;
    c_addr  = lat_addr;
    c_wdata = lat_wdata;
    if (state == IDLE) begin
      c_write = req_write;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end
    c_err = ({1'b0, c_addr} >= LIMIT);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    c_err = c_err | (c_addr[1:0] != 2'b00);
`endif
    c_idx  = c_addr[AW+1:2];
    commit = 1'b0;
    if (!reset) begin
      if (state == IDLE)      commit = req_valid && (WAIT_CYCLES == 0);
      else if (state == WAIT) commit = (cnt == 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (commit && c_write && !c_err) mem[c_idx] <= c_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
    end else begin
      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= c_err;
        rsp_rdata <= (c_write || c_err) ? 32'h0 : mem[c_idx];
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= 4'(WAIT_CYCLES);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, backpressure/reset sequences, random traffic vs model.
module tb_mem_responder;
  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model_mem [DEPTH];
  logic [32:0] exp_q [$];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;
  vec_t tbl [12];

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: memory as a plain array, errors from address arithmetic.
  function automatic logic [32:0] model_op(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic err;
    int   idx;
    err = (a >= 32'(DEPTH * 4));
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    if (a % 4 != 0) err = 1'b1;
`endif
    idx = int'(a / 4);
    if (err) return {1'b1, 32'h0};
    if (w) begin
      model_mem[idx] = d;
      return 33'h0;
    end
    return {1'b0, model_mem[idx]};
  endfunction

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output logic er);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // noise that must be ignored while the request is in flight
    req_valid = 1'($urandom_range(0, 1)); req_write = ~w;
    req_addr = $urandom; req_wdata = $urandom; rsp_ready = 1'($urandom_range(0, 1));
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("latency", 32'(lat), 32'(WAIT_CYCLES));
    check("busy_resp", 32'(busy), 32'd1);
    check("req_ready_resp", 32'(req_ready), 32'd0);
    rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0; req_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, rd);
      check("hold_err", 32'(rsp_err), 32'(er));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("done_valid", 32'(rsp_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_req_ready", 32'(req_ready), 32'd1);
    check("done_rdata", rsp_rdata, 32'h0);
    check("done_err", 32'(rsp_err), 32'd0);
  endtask

  // scoreboard: expectation from model queued before issue, popped at response
  task automatic apply(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold,
                       output logic [31:0] rd, output logic er);
    logic [32:0] e;
    exp_q.push_back(model_op(w, a, d));
    do_txn(w, a, d, hold, rd, er);
    e = exp_q.pop_front();
    check("sb_rdata", rd, e[31:0]);
    check("sb_err", 32'(er), 32'(e[32]));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    logic        w;

    // clock / reset
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", 32'(rsp_err), 32'd0);

    // known contents everywhere
    for (int i = 0; i < DEPTH; i++) apply(1'b1, 32'(i * 4), 32'hC0DE0000 | 32'(i), 0, rd, er);

    tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h400,      32'h12345678, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 32'h3FC,      32'h0,        1'b0, 32'hC0DE00FF};
    tbl[4]  = '{1'b0, 32'h400,      32'h0,        1'b1, 32'h0};
    tbl[5]  = '{1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0};
    tbl[6]  = '{1'b1, 32'h3FC,      32'hCAFEF00D, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h3FC,      32'h0,        1'b0, 32'hCAFEF00D};
    tbl[8]  = '{1'b1, 32'h8,        32'h11,       1'b0, 32'h0};
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    tbl[9]  = '{1'b1, 32'h9,        32'h22,       1'b1, 32'h0};
    tbl[10] = '{1'b0, 32'h8,        32'h0,        1'b0, 32'h11};
    tbl[11] = '{1'b0, 32'hB,        32'h0,        1'b1, 32'h0};
`else
    tbl[9]  = '{1'b1, 32'h9,        32'h22,       1'b0, 32'h0};
    tbl[10] = '{1'b0, 32'h8,        32'h0,        1'b0, 32'h22};
    tbl[11] = '{1'b0, 32'hB,        32'h0,        1'b0, 32'h22};
`endif
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].w, tbl[i].a, tbl[i].d, i % 3, rd, er);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].e_rd);
      check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].e_err));
    end

    // response backpressure on a load
    apply(1'b0, 32'h10, 32'h0, 4, rd, er);
    check("bp_rdata", rd, 32'hDEADBEEF);

    // reset in the middle of a store's wait states
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1; #1;
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rdata", rsp_rdata, 32'h0);
    check("arst_err", 32'(rsp_err), 32'd0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    apply(1'b0, 32'h20, 32'h0, 0, rd, er);
    check("abort_load", rd, 32'hC0DE0008);

    // random traffic against the model
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom | 32'h400;
        1:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      endcase
      w = 1'($urandom_range(0, 1));
      apply(w, a, $urandom, $urandom_range(0, 3), rd, er);
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
